// File: rtl/sha3_absorb_pad.sv
// sha3_absorb_pad
//   Collects an AXI-Stream message into Keccak rate blocks. It applies SHA-3
//   domain padding (0x06 ... 0x80) to the final block and hands each 1600-bit
//   block to the permutation core with a valid/ready handshake. The capacity
//   bytes of each block are always zero.
//
// Ports
//   ACLK, ARESET    clock, synchronous active-high reset
//   S_TDATA/TKEEP   message word and contiguous-from-LSB byte mask
//   S_TLAST         final word of the message
//   S_TUSER         variant (0..3 = SHA3-224/256/384/512), taken from the first word
//   S_TVALID/TREADY input handshake
//   M_BLOCK         1600-bit Keccak state block, message byte k at [8k+7:8k]
//   M_TUSER, M_LAST variant and final-block flag of the presented block
//   M_VALID/M_READY output handshake
module sha3_absorb_pad #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [DATA_WIDTH-1:0]   S_TDATA,
  input  logic [DATA_WIDTH/8-1:0] S_TKEEP,
  input  logic                    S_TLAST,
  input  logic [1:0]              S_TUSER,
  input  logic                    S_TVALID,
  output logic                    S_TREADY,
  output logic [1599:0]           M_BLOCK,
  output logic [1:0]              M_TUSER,
  output logic                    M_LAST,
  output logic                    M_VALID,
  input  logic                    M_READY
);

  localparam int BPW      = DATA_WIDTH / 8;
  localparam int BPW_LOG2 = $clog2(BPW);

  typedef enum logic [1:0] {FILL, PAD, EMIT} state_e;

  state_e          state_q;
  logic [7:0]      wordCnt_q;
  logic [7:0]      padPtr_q;
  logic            firstWord_q;
  logic            padPending_q;
  logic [1:0]      var_q;
  logic            last_q;
  logic [1599:0]   block_q;
  logic            tready_q;
  logic            mvalid_q;

  logic [DATA_WIDTH-1:0] maskedData_d;
  logic [7:0]            keepCnt_d;
  logic [1:0]            effVar_d;
  logic [7:0]            rate_d;
  logic [7:0]            lastSlot_d;
  logic [7:0]            padPtr_d;
  logic [10:0]           wordBase_d;
  logic [7:0]            padEnd_d;
  logic [1599:0]         padBlock_d;

  // Rate in bytes for each variant.
  function automatic logic [7:0] rateOf(input logic [1:0] v);
    case (v)
      2'd0:    rateOf = 8'd144;
      2'd1:    rateOf = 8'd136;
      2'd2:    rateOf = 8'd104;
      default: rateOf = 8'd72;
    endcase
  endfunction

  // Word-level decode. On the first word of a message the variant register
  // has not been loaded yet, so block size decisions use S_TUSER directly.
  always_comb begin
    maskedData_d = '0;
    keepCnt_d    = '0;
    for (int i = 0; i < BPW; i++) begin
      maskedData_d[8*i +: 8] = S_TKEEP[i] ? S_TDATA[8*i +: 8] : 8'h00;
      keepCnt_d = keepCnt_d + {7'd0, S_TKEEP[i]};
    end
    effVar_d   = firstWord_q ? S_TUSER : var_q;
    rate_d     = rateOf(effVar_d);
    lastSlot_d = (rate_d >> BPW_LOG2) - 8'd1;
    padPtr_d   = (wordCnt_q << BPW_LOG2) + keepCnt_d;
    wordBase_d = 11'(wordCnt_q) << (BPW_LOG2 + 3);
  end

  // Padded copy of the buffer. Both bytes are XORed so a pad pointer landing
  // on the last rate byte naturally yields 0x86.
  always_comb begin
    padEnd_d   = rateOf(var_q) - 8'd1;
    padBlock_d = block_q;
    padBlock_d[{padPtr_q, 3'b000} +: 8] = padBlock_d[{padPtr_q, 3'b000} +: 8] ^ 8'h06;
    padBlock_d[{padEnd_d, 3'b000} +: 8] = padBlock_d[{padEnd_d, 3'b000} +: 8] ^ 8'h80;
  end

  // Main FSM. A message that ends exactly on a block boundary emits that
  // block unpadded and then pads a fresh all-zero block (padPending_q).
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= FILL;
      wordCnt_q    <= '0;
      padPtr_q     <= '0;
      firstWord_q  <= 1'b1;
      padPending_q <= 1'b0;
      var_q        <= '0;
      last_q       <= 1'b0;
      block_q      <= '0;
      tready_q     <= 1'b0;
      mvalid_q     <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          tready_q <= 1'b1;
          if (S_TVALID && tready_q) begin
            block_q[wordBase_d +: DATA_WIDTH] <= maskedData_d;
            if (firstWord_q) begin
              var_q       <= S_TUSER;
              firstWord_q <= 1'b0;
            end
            if (!S_TLAST) begin
              if (wordCnt_q == lastSlot_d) begin
                wordCnt_q <= '0;
                last_q    <= 1'b0;
                tready_q  <= 1'b0;
                mvalid_q  <= 1'b1;
                state_q   <= EMIT;
              end else begin
                wordCnt_q <= wordCnt_q + 8'd1;
              end
            end else begin
              padPtr_q <= padPtr_d;
              tready_q <= 1'b0;
              if (padPtr_d == rate_d) begin
                wordCnt_q    <= '0;
                last_q       <= 1'b0;
                padPending_q <= 1'b1;
                mvalid_q     <= 1'b1;
                state_q      <= EMIT;
              end else begin
                state_q <= PAD;
              end
            end
          end
        end
        PAD: begin
          block_q  <= padBlock_d;
          last_q   <= 1'b1;
          mvalid_q <= 1'b1;
          state_q  <= EMIT;
        end
        EMIT: begin
          if (M_READY) begin
            block_q  <= '0;
            mvalid_q <= 1'b0;
            if (padPending_q) begin
              padPtr_q     <= '0;
              padPending_q <= 1'b0;
              state_q      <= PAD;
            end else begin
              if (last_q) begin
                firstWord_q <= 1'b1;
                wordCnt_q   <= '0;
              end
              tready_q <= 1'b1;
              state_q  <= FILL;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign S_TREADY = tready_q;
  assign M_VALID  = mvalid_q;
  assign M_BLOCK  = block_q;
  assign M_TUSER  = var_q;
  assign M_LAST   = last_q;

endmodule

// File: tb/tb_sha3_absorb_pad.sv
// tb_sha3_absorb_pad
//   Directed bench for sha3_absorb_pad at DATA_WIDTH=16. Stimulus pushes the
//   expected blocks into a queue; an independent monitor pops and compares
//   each block the DUT presents, and throttles M_READY to create stalls.
module tb_sha3_absorb_pad;

  localparam int DW  = 16;
  localparam int BPW = DW / 8;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic [DW-1:0]   S_TDATA;
  logic [BPW-1:0]  S_TKEEP;
  logic            S_TLAST;
  logic [1:0]      S_TUSER;
  logic            S_TVALID;
  logic            S_TREADY;
  logic [1599:0]   M_BLOCK;
  logic [1:0]      M_TUSER;
  logic            M_LAST;
  logic            M_VALID;
  logic            M_READY = 1'b0;

  always #5 ACLK = ~ACLK;

  sha3_absorb_pad #(.DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_TDATA(S_TDATA), .S_TKEEP(S_TKEEP), .S_TLAST(S_TLAST),
    .S_TUSER(S_TUSER), .S_TVALID(S_TVALID), .S_TREADY(S_TREADY),
    .M_BLOCK(M_BLOCK), .M_TUSER(M_TUSER), .M_LAST(M_LAST),
    .M_VALID(M_VALID), .M_READY(M_READY)
  );

  typedef struct {
    logic [1599:0] blk;
    logic [1:0]    user;
    logic          last;
  } exp_t;

  exp_t          expQ[$];
  exp_t          curExp;
  logic [7:0]    msgQ[$];
  int            testsRun    = 0;
  int            testsFailed = 0;
  int            stallCycles = 0;
  int            waitCnt     = 0;
  bit            inBlock     = 0;

  // Scalar comparison with failure reporting.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Block comparison reports only the first differing byte to keep lines short.
  task automatic checkBlock(input string name, input logic [1599:0] act, input logic [1599:0] exp);
    int idx;
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      idx = 0;
      for (int i = 0; i < 200; i++) begin
        if (act[8*i +: 8] !== exp[8*i +: 8]) begin
          idx = i;
          break;
        end
      end
      $display("[TB] FAIL %s: byte %0d got %02h, expected %02h", name, idx, act[8*idx +: 8], exp[8*idx +: 8]);
    end
  endtask

  function automatic int rateOf(input logic [1:0] v);
    case (v)
      2'd0:    rateOf = 144;
      2'd1:    rateOf = 136;
      2'd2:    rateOf = 104;
      default: rateOf = 72;
    endcase
  endfunction

  task automatic pushExp(input logic [1599:0] blk, input logic [1:0] user, input logic last);
    exp_t e;
    e.blk  = blk;
    e.user = user;
    e.last = last;
    expQ.push_back(e);
  endtask

  // Byte-level SHA-3 padding of msgQ into rate blocks.
  task automatic pushModel(input logic [1:0] user);
    int len, r, nb, rem;
    logic [1599:0] blk;
    len = msgQ.size();
    r   = rateOf(user);
    nb  = len / r + 1;
    for (int b = 0; b < nb; b++) begin
      blk = '0;
      for (int j = 0; j < r; j++)
        if (b * r + j < len) blk[8*j +: 8] = msgQ[b * r + j];
      if (b == nb - 1) begin
        rem = len - b * r;
        blk[8*rem +: 8]     = blk[8*rem +: 8] ^ 8'h06;
        blk[8*(r-1) +: 8]   = blk[8*(r-1) +: 8] ^ 8'h80;
      end
      pushExp(blk, user, b == nb - 1);
    end
  endtask

  task automatic fillPattern(input int len);
    msgQ.delete();
    for (int k = 0; k < len; k++) msgQ.push_back(8'(k + 1));
  endtask

  // Sends msgQ as a stream. Called and returns just after a falling edge.
  // Later words carry an inverted TUSER, which the DUT must ignore.
  task automatic applyStimulus(input logic [1:0] user, input bit noLast);
    int len, nWords, sent, r, n, kept;
    bit last, exact;
    len    = msgQ.size();
    nWords = (len == 0) ? 1 : (len + BPW - 1) / BPW;
    r      = rateOf(user);
    sent   = 0;
    for (int w = 0; w < nWords; w++) begin
      kept = 0;
      for (int j = 0; j < BPW; j++) begin
        if (w * BPW + j < len) begin
          S_TDATA[8*j +: 8] = msgQ[w * BPW + j];
          S_TKEEP[j]        = 1'b1;
          kept++;
        end else begin
          S_TDATA[8*j +: 8] = 8'hA5;
          S_TKEEP[j]        = 1'b0;
        end
      end
      last     = (w == nWords - 1) && !noLast;
      S_TLAST  = last;
      S_TUSER  = (w == 0) ? user : ~user;
      S_TVALID = 1'b1;
      n = 0;
      while (!S_TREADY && n < 200) begin
        @(negedge ACLK);
        n++;
      end
      if (!S_TREADY) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL accept timeout: word %0d not accepted", w);
      end
      @(negedge ACLK);
      sent += kept;
      if (!last && !noLast && (sent % r == 0))
        checkOutput("valid after full block", M_VALID, 1);
      if (last) begin
        exact = (len > 0) && (sent % r == 0);
        checkOutput("valid after last word", M_VALID, exact);
        if (!exact) begin
          S_TVALID = 1'b0;
          @(negedge ACLK);
          checkOutput("valid after pad cycle", M_VALID, 1);
        end
      end
    end
    S_TVALID = 1'b0;
    S_TLAST  = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || M_VALID) && n < 3000) begin
      @(negedge ACLK);
      n++;
    end
    if (expQ.size() != 0 || M_VALID) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain timeout: %0d blocks outstanding", expQ.size());
    end
    repeat (3) @(negedge ACLK);
  endtask

  // Monitor: compares each presented block on its first valid cycle, holds
  // M_READY low for stallCycles cycles and checks the block stays put.
  initial begin
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        inBlock = 0;
        M_READY = (stallCycles == 0);
      end else if (M_VALID) begin
        if (!inBlock) begin
          if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpected block: M_LAST=%0d M_TUSER=%0d", M_LAST, M_TUSER);
            curExp.blk = M_BLOCK;
          end else begin
            curExp = expQ.pop_front();
            checkBlock("block contents", M_BLOCK, curExp.blk);
            checkOutput("block tuser", M_TUSER, curExp.user);
            checkOutput("block last", M_LAST, curExp.last);
          end
          inBlock = 1;
          waitCnt = 0;
        end else begin
          checkBlock("block stable in stall", M_BLOCK, curExp.blk);
          checkOutput("tready low in stall", S_TREADY, 0);
        end
        if (waitCnt < stallCycles) begin
          M_READY = 1'b0;
          waitCnt++;
        end else begin
          M_READY = 1'b1;
          inBlock = 0;
        end
      end else begin
        M_READY = (stallCycles == 0);
      end
    end
  end

  // Flags illegal keep masks on accepted words.
  always @(posedge ACLK) begin
    if (!ARESET && S_TVALID && S_TREADY)
      assert (((S_TKEEP & (S_TKEEP + 1'b1)) == '0) && (S_TLAST || S_TKEEP == '1))
        else $error("[TB] illegal TKEEP %b", S_TKEEP);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios.
  initial begin
    logic [1599:0] blk;
    ARESET   = 1'b1;
    S_TDATA  = '0;
    S_TKEEP  = '0;
    S_TLAST  = 1'b0;
    S_TUSER  = '0;
    S_TVALID = 1'b0;
    repeat (3) @(negedge ACLK);
    checkOutput("reset S_TREADY", S_TREADY, 0);
    checkOutput("reset M_VALID", M_VALID, 0);
    checkOutput("reset M_LAST", M_LAST, 0);
    checkOutput("reset M_TUSER", M_TUSER, 0);
    checkBlock("reset M_BLOCK", M_BLOCK, '0);
    ARESET = 1'b0;
    @(negedge ACLK);
    checkOutput("S_TREADY after reset", S_TREADY, 1);

    $display("[TB] SHA3-256 empty message");
    msgQ.delete();
    blk = '0;
    blk[7:0]         = 8'h06;
    blk[135*8 +: 8]  = 8'h80;
    pushExp(blk, 2'd1, 1'b1);
    applyStimulus(2'd1, 0);
    waitDrain();

    $display("[TB] SHA3-256 abc");
    msgQ = '{8'h61, 8'h62, 8'h63};
    blk = '0;
    blk[63:0]        = 64'h0000000006636261;
    blk[135*8 +: 8]  = 8'h80;
    pushExp(blk, 2'd1, 1'b1);
    applyStimulus(2'd1, 0);
    waitDrain();

    $display("[TB] SHA3-256 135 and 136 byte messages");
    fillPattern(135);
    pushModel(2'd1);
    applyStimulus(2'd1, 0);
    waitDrain();
    fillPattern(136);
    pushModel(2'd1);
    applyStimulus(2'd1, 0);
    waitDrain();

    $display("[TB] SHA3-512 200 bytes with stalls");
    stallCycles = 5;
    fillPattern(200);
    pushModel(2'd3);
    applyStimulus(2'd3, 0);
    waitDrain();
    stallCycles = 0;
    @(negedge ACLK);

    $display("[TB] back-to-back messages");
    msgQ = '{8'h61, 8'h62, 8'h63};
    blk = '0;
    blk[31:0]        = 32'h06636261;
    blk[143*8 +: 8]  = 8'h80;
    pushExp(blk, 2'd0, 1'b1);
    applyStimulus(2'd0, 0);
    msgQ.delete();
    blk = '0;
    blk[7:0]         = 8'h06;
    blk[71*8 +: 8]   = 8'h80;
    pushExp(blk, 2'd3, 1'b1);
    applyStimulus(2'd3, 0);
    waitDrain();

    $display("[TB] reset mid-message");
    fillPattern(20);
    applyStimulus(2'd0, 1);
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    checkOutput("mid reset S_TREADY", S_TREADY, 0);
    checkOutput("mid reset M_VALID", M_VALID, 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    msgQ.delete();
    blk = '0;
    blk[7:0]         = 8'h06;
    blk[143*8 +: 8]  = 8'h80;
    pushExp(blk, 2'd0, 1'b1);
    applyStimulus(2'd0, 0);
    waitDrain();
    checkOutput("no outstanding blocks", 64'(expQ.size()), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sha3_absorb_pad.md
Name: sha3_absorb_pad

Overview:
Upstream neighbour of the Keccak permutation core. Accepts a message as an AXI-Stream of DATA_WIDTH-bit words and assembles rate-sized blocks. Applies SHA-3 domain padding (0x06 … 0x80) to the final block. Presents each 1600-bit block (capacity zeroed) to the core with a valid/ready handshake, tagged with the variant select and a last-block flag. Variant coding matches the output serializer: TUSER 0/1/2/3 = SHA3-224/256/384/512.

Parameters:
DATA_WIDTH, 16, stream word width in bits; legal values 8, 16, 32, 64.

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
S_TDATA  in  DATA_WIDTH  message word; byte i = S_TDATA[8i+7:8i] is the earlier-in-message byte for smaller i
S_TKEEP  in  DATA_WIDTH/8  valid-byte mask, contiguous from LSB; all ones unless S_TLAST; all zero legal only with S_TLAST
S_TLAST  in  1  final word of message
S_TUSER  in  2  variant; sampled on the first word of a message
S_TVALID  in  1  word valid
S_TREADY  out  1  word accepted when S_TVALID&S_TREADY
M_BLOCK  out  1600  Keccak block; lane L=x+5y at bits [64L+63:64L]; message byte k at bits [8k+7:8k]
M_TUSER  out  2  variant of this block's message
M_LAST  out  1  block is the final block of the message
M_VALID  out  1  block valid
M_READY  in  1  core accepts block

Behaviour:
- Rate R bytes: 144/136/104/72 for TUSER 0/1/2/3. Words per block WPB = R*8/DATA_WIDTH (DW16: 72/68/52/36).
- Reset values: S_TREADY=0, M_VALID=0, M_LAST=0, M_TUSER=0, M_BLOCK=0. State=FILL, word_cnt=0, first_word=1. S_TREADY goes to 1 the cycle after ARESET deasserts.
- Reset mid-operation discards the partial block and the message. The next accepted word is treated as a first word.
- States:
  - FILL: S_TREADY=1, M_VALID=0. On accept, write S_TDATA into word slot word_cnt (bytes with TKEEP=0 are written as 0x00). If first_word, latch S_TUSER into var_reg and clear first_word.
    - Not S_TLAST and word_cnt==WPB-1 -> EMIT with last_reg=0, word_cnt=0.
    - Not S_TLAST otherwise -> word_cnt+1.
    - S_TLAST -> pad_ptr = word_cnt*(DATA_WIDTH/8) + popcount(S_TKEEP).
      - If pad_ptr==R (block exactly full) -> EMIT with last_reg=0 and pad_pending=1.
      - Else -> PAD.
  - PAD (1 cycle, S_TREADY=0): byte[pad_ptr] ^= 0x06; byte[R-1] ^= 0x80. If pad_ptr==R-1, that byte becomes 0x86. Then -> EMIT with last_reg=1.
  - EMIT: S_TREADY=0, M_VALID=1. M_BLOCK, M_TUSER=var_reg, M_LAST=last_reg are held stable until M_READY.
    - On M_VALID&M_READY: clear the block buffer to 0.
    - If pad_pending: pad_ptr=0, clear pad_pending, -> PAD.
    - Else if last_reg: first_word=1, word_cnt=0, -> FILL.
    - Else -> FILL.
- Capacity bytes R..199 are always 0.
- Latency:
  - Non-final full block: last word accepted at cycle N -> M_VALID at N+1.
  - Final block: last word accepted at N -> PAD at N+1 -> M_VALID at N+2.
  - With M_READY=1, FILL resumes at the cycle after the handshake.
- A new message may start in the first FILL cycle after a final-block handshake. No bubble beyond that cycle.
- S_TUSER changes mid-message are ignored.
- A TKEEP that is non-contiguous or all zero without S_TLAST is illegal. Behaviour for it is unspecified; the bench flags it with an assertion.

Test Plan:
- SHA3-256, empty message (single word, TKEEP=00, TLAST) -> one block: byte0=0x06, byte135=0x80, all other bytes 0, M_LAST=1, M_TUSER=1, M_VALID 2 cycles after accept.
- SHA3-256 "abc", DW16: words 0x6261 (TKEEP=11), 0x0063 (TKEEP=01, TLAST) -> bytes 61 62 63 06, byte135=0x80, lanes 0 = 0x0000000006636261, M_LAST=1.
- SHA3-256, 135-byte message -> single block, byte134 = last data byte, byte135=0x86. 136-byte message -> block1 all data with M_LAST=0, then block2 byte0=0x06, byte135=0x80, M_LAST=1.
- SHA3-512, 200-byte message, M_READY held 0 for 5 cycles on each block -> 3 blocks (72+72+56 data bytes, pad at byte 56). S_TREADY=0 and M_BLOCK stable throughout stalls. Capacity bytes 72..199 = 0.
- Back-to-back messages: TUSER=0 "abc" then TUSER=3 empty -> second block M_TUSER=3, no stale bytes from first message.
- ARESET pulsed after 10 words of a SHA3-224 message, then a new empty message -> only the empty-message block appears (byte0=0x06, byte143=0x80).
